// File: rtl/router_pkg.sv
// Router-wide constants shared by the crossbar and port stages.
// VC and port indices match the crossbar grant ordering.
package router_pkg;

    localparam int DATA_W = 64;

    localparam logic VC_EVEN = 1'b0;
    localparam logic VC_ODD  = 1'b1;

    localparam int PORT_N  = 4;
    localparam int PORT_S  = 3;
    localparam int PORT_E  = 2;
    localparam int PORT_W  = 1;
    localparam int PORT_PE = 0;

endpackage

// File: rtl/vc_slot.sv
// Single-entry VC buffer: captures a word when empty; full is visible one edge after the enqueue.
// An enqueue into a full slot is dropped and flagged on ovf. deq empties the slot at the edge.
module vc_slot
    import router_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enq,
    input  logic [W-1:0] d_in,
    input  logic         deq,
    output logic         valid,
    output logic [W-1:0] q,
    output logic         ovf
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (deq) begin
            valid_d = 1'b0;
        end
        // A same-edge enqueue and dequeue cannot both land: the enqueue sees a full slot.
        if (enq && !valid_q) begin
            valid_d = 1'b1;
            data_d  = d_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign q     = data_q;
    assign ovf   = enq & valid_q;

endmodule

// File: rtl/outbuf_port.sv
// Router output port: one slot per VC, the external VC (= polarity) sends on valid & ro.
// Send is registered (so/dout one edge after fire); ro=0 holds the packet in its slot.
module outbuf_port
    import router_pkg::*;
#(
    parameter int DATA_W = router_pkg::DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              polarity,
    input  logic              enq_vc0,
    input  logic [DATA_W-1:0] d_in_vc0,
    input  logic              enq_vc1,
    input  logic [DATA_W-1:0] d_in_vc1,
    output logic              full_vc0,
    output logic              full_vc1,
    input  logic              ro,
    output logic              so,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  tx_count,
    output logic              err_ovf
);

    logic              valid0, valid1, ovf0, ovf1;
    logic [DATA_W-1:0] q0, q1;
    logic              valid_ext, fire, deq0, deq1;
    logic [DATA_W-1:0] data_ext;

    logic              so_q, so_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    vc_slot #(.W(DATA_W)) u_slot_vc0 (
        .clk   (clk),
        .reset (reset),
        .enq   (enq_vc0),
        .d_in  (d_in_vc0),
        .deq   (deq0),
        .valid (valid0),
        .q     (q0),
        .ovf   (ovf0)
    );

    vc_slot #(.W(DATA_W)) u_slot_vc1 (
        .clk   (clk),
        .reset (reset),
        .enq   (enq_vc1),
        .d_in  (d_in_vc1),
        .deq   (deq1),
        .valid (valid1),
        .q     (q1),
        .ovf   (ovf1)
    );

    // Only the external VC may drain; the internal VC just holds.
    assign valid_ext = (polarity == VC_ODD) ? valid1 : valid0;
    assign data_ext  = (polarity == VC_ODD) ? q1 : q0;
    assign fire      = valid_ext & ro;
    assign deq0      = fire & (polarity == VC_EVEN);
    assign deq1      = fire & (polarity == VC_ODD);

    always_comb begin
        so_d   = fire;
        dout_d = dout_q;
        cnt_d  = cnt_q;
        err_d  = err_q | ovf0 | ovf1;
        if (fire) begin
            dout_d = data_ext;
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            so_q   <= 1'b0;
            dout_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            so_q   <= so_d;
            dout_q <= dout_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign full_vc0 = valid0;
    assign full_vc1 = valid1;
    assign so       = so_q;
    assign dout     = dout_q;
    assign tx_count = cnt_q;
    assign err_ovf  = err_q;

endmodule

// File: doc/outbuf_port.md
Name: outbuf_port

Overview:
- Output-side stage of one router port, directly downstream of the internal crossbar.
- Holds one single-entry buffer per virtual channel (VC0 even, VC1 odd).
- Each buffer accepts a packet from the crossbar enqueue interface, then drives it onto the inter-router link during that VC's external phase, using a send/ready handshake.
- Five instances per router: N, S, E, W, PE.

Parameters:
- DATA_W, 64, packet width in bits.
- CNT_W, 16, width of the transmitted-packet counter.

Ports:
- clk  input  1  router clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- polarity  input  1  phase select. 0: VC0 external / VC1 internal. 1: VC1 external / VC0 internal.
- enq_vc0  input  1  crossbar enqueue strobe for VC0.
- d_in_vc0  input  DATA_W  VC0 enqueue data.
- enq_vc1  input  1  crossbar enqueue strobe for VC1.
- d_in_vc1  input  DATA_W  VC1 enqueue data.
- full_vc0  output  1  VC0 slot occupied; feeds the crossbar outbuf_full for VC0.
- full_vc1  output  1  VC1 slot occupied.
- ro  input  1  downstream router ready for the currently external VC.
- so  output  1  registered send strobe, one cycle per packet.
- dout  output  DATA_W  registered link data.
- tx_count  output  CNT_W  packets sent since reset, wraps.
- err_ovf  output  1  sticky: enqueue attempted while the slot was full.

Behaviour:
- Reset (reset=0, asynchronous): both slots empty, so=0, dout=0, tx_count=0, err_ovf=0. Outputs stay at these values while reset is held.
- Slot state: a valid bit plus a DATA_W data register per VC. full_vcX = valid_X, driven directly from the flop with no combinational path from inputs.
- Enqueue, VC x:
  - enq_vcx=1 and valid_x=0 → at the edge, data_x <= d_in_vcx and valid_x <= 1.
  - enq_vcx=1 and valid_x=1 → data is dropped, slot unchanged, err_ovf <= 1. err_ovf is cleared only by reset.
- External VC: ext = polarity.
- Send condition, evaluated combinationally each cycle: fire = valid_ext & ro.
  - At the edge with fire=1: so <= 1, dout <= data_ext, valid_ext <= 0, tx_count <= tx_count+1 (mod 2^CNT_W).
  - At the edge with fire=0: so <= 0, dout holds its previous value.
- Latency:
  - enq at edge k → full visible after edge k.
  - Earliest send edge is k+1, if that cycle is the VC's external phase and ro=1.
  - so is asserted in the cycle after the edge where fire was sampled.
- Phase rules:
  - The internal VC never sends.
  - Enqueue is accepted on either VC whenever its slot is empty, independent of polarity. Phase gating of enqueue belongs to the crossbar, not this block.
- Simultaneous events:
  - Enqueue to VC a and send from VC b≠a on the same edge: both take effect.
  - Enqueue and send on the same VC at the same edge: the slot is full, so the enqueue is an overflow and is dropped. The send proceeds and the slot ends empty.
- ro=0 while the external slot is full: the packet holds, so=0. Retry happens on the next external phase of that VC.
- Both slots full: ordering is set purely by polarity. There is no cross-VC arbitration.
- Reset asserted mid-operation: buffered packets are discarded, no so pulse is generated, and the counter returns to 0.
- tx_count wraps from 2^CNT_W-1 to 0 silently.
- Implementation target: ~150–250 lines of RTL.

Decomposition:
- Shared package router_pkg:
  - DATA_W.
  - VC index constants VC_EVEN=0, VC_ODD=1.
  - Port index constants PORT_N=4, PORT_S=3, PORT_E=2, PORT_W=1, PORT_PE=0, matching the crossbar grant ordering.
- Sub-module vc_slot: single-entry buffer with ports clk, reset, enq, d_in, deq, valid, q, ovf. Instantiated twice; the top level contains the phase select, send register and counter.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, release → so=0, dout=0, full_vc0=full_vc1=0, tx_count=0, err_ovf=0.
- Basic send: enq_vc0 with 0x0000_0000_DEAD_BEEF while polarity=1; then polarity=0, ro=1 → full_vc0 drops after that edge; so=1 for exactly one cycle with dout=0x...DEADBEEF; tx_count=1.
- Back-pressure: VC1 holds 0xA5A5…, polarity=1, ro=0 for 4 external phases, then ro=1 → so stays 0 and full_vc1 stays 1 throughout; a single so pulse follows once ro=1.
- Overflow: VC0 full with 0x11, second enq_vc0 with 0x22 → err_ovf=1 and stays 1; a later send outputs 0x11, never 0x22.
- Alternating traffic: both VCs loaded (VC0=0x1, VC1=0x2), polarity toggling every cycle starting at 0, ro=1 → so pulses on consecutive cycles, dout=0x1 then 0x2, tx_count=2.
- Mid-op reset / wrap: preload tx_count near 0xFFFF by sending 65535 packets, send one more → tx_count=0. Assert reset while VC1 is full → full_vc1=0 immediately (asynchronous), and no so pulse after release.
